// File: rtl/axi_pkg.sv
// Shared AXI definitions: bus width defaults, burst/size encodings and the
// AWLEN type used by the write-side blocks.
package axi_pkg;

  localparam int AXI_DW_DEF = 128;
  localparam int AXI_LW_DEF = 8;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [2:0] AXI_SIZE_1B   = 3'd0;
  localparam logic [2:0] AXI_SIZE_2B   = 3'd1;
  localparam logic [2:0] AXI_SIZE_4B   = 3'd2;
  localparam logic [2:0] AXI_SIZE_8B   = 3'd3;
  localparam logic [2:0] AXI_SIZE_16B  = 3'd4;
  localparam logic [2:0] AXI_SIZE_32B  = 3'd5;
  localparam logic [2:0] AXI_SIZE_64B  = 3'd6;
  localparam logic [2:0] AXI_SIZE_128B = 3'd7;

  typedef logic [AXI_LW_DEF-1:0] axlen_t;

endpackage

// File: rtl/axi_cmd_fifo.sv
// Generic synchronous FIFO. A push while full is dropped even when a pop
// happens in the same cycle; the caller only pops when non-empty.
module axi_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    cnt,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];
  assign cnt     = cnt_q;

  // Pointers wrap naturally (power-of-two depth); occupancy tells full from empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage array; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/axi_wbeat_gen.sv
// Write-data beat generator: queues AWLEN of each accepted AW burst and turns
// a valid/ready source stream into W beats with wlast and full strobes.
module axi_wbeat_gen
  import axi_pkg::*;
#(
  parameter int AXI_DW    = AXI_DW_DEF,
  parameter int AXI_LW    = AXI_LW_DEF,
  parameter int CMD_D     = 4,
  parameter int AXI_BYTES = AXI_DW / 8,
  parameter int CNT_W     = $clog2(CMD_D + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 aw_push,
  input  logic [AXI_LW-1:0]    aw_len,
  output logic                 cmd_full,
  input  logic [AXI_DW-1:0]    src_data,
  input  logic                 src_valid,
  output logic                 src_ready,
  output logic [AXI_DW-1:0]    wdata,
  output logic [AXI_BYTES-1:0] wstrb,
  output logic                 wlast,
  output logic                 wvalid,
  input  logic                 wready,
  output logic                 burst_done,
  output logic                 busy,
  input  logic                 err_clr,
  output logic                 err_ovf
);

  typedef enum logic {IDLE, DATA} st_e;

  st_e               st_q;
  logic [AXI_LW-1:0] beat_rem_q;
  logic              err_ovf_q;

  logic [AXI_LW-1:0] cmd_head;
  logic [CNT_W-1:0]  cmd_cnt;
  logic              cmd_full_w;
  logic              cmd_empty;
  logic              cmd_pop;
  logic              in_data;
  logic              beat_hs;
  logic              beat_last;

  axi_cmd_fifo #(
    .WIDTH (AXI_LW),
    .DEPTH (CMD_D)
  ) u_cmd_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (aw_push),
    .pop   (cmd_pop),
    .din   (aw_len),
    .dout  (cmd_head),
    .cnt   (cmd_cnt),
    .full  (cmd_full_w),
    .empty (cmd_empty)
  );

  assign in_data   = (st_q == DATA);
  assign beat_last = (beat_rem_q == '0);
  assign beat_hs   = in_data & src_valid & wready;
  // Pop on entry from IDLE, or on the last beat so the next burst follows with no bubble.
  assign cmd_pop   = ~cmd_empty & ((st_q == IDLE) | (beat_hs & beat_last));

  // Burst sequencing: beat_rem only moves on a handshake so wlast is stable under stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q       <= IDLE;
      beat_rem_q <= '0;
    end else begin
      case (st_q)
        IDLE: begin
          if (!cmd_empty) begin
            beat_rem_q <= cmd_head;
            st_q       <= DATA;
          end
        end
        DATA: begin
          if (beat_hs) begin
            if (!beat_last) begin
              beat_rem_q <= beat_rem_q - AXI_LW'(1);
            end else if (!cmd_empty) begin
              beat_rem_q <= cmd_head;
            end else begin
              st_q <= IDLE;
            end
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  // Sticky overflow flag; a dropped push wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_ovf_q <= 1'b0;
    end else if (aw_push && cmd_full_w) begin
      err_ovf_q <= 1'b1;
    end else if (err_clr) begin
      err_ovf_q <= 1'b0;
    end
  end

  // W channel pass-through, gated off outside a burst.
  always_comb begin
    wvalid     = in_data & src_valid;
    src_ready  = in_data & wready;
    wlast      = in_data & beat_last;
    wstrb      = in_data ? {AXI_BYTES{1'b1}} : {AXI_BYTES{1'b0}};
    wdata      = src_data;
    burst_done = beat_hs & beat_last;
    busy       = in_data | (cmd_cnt != '0);
    cmd_full   = cmd_full_w;
    err_ovf    = err_ovf_q;
  end

endmodule

// File: tb/tb_axi_wbeat_gen.sv
// Directed bench for axi_wbeat_gen: single, back-to-back, backpressure,
// overflow, max-length and reset-mid-burst scenarios.
module tb_axi_wbeat_gen;

  localparam int DW = 32;
  localparam int LW = 8;
  localparam int CD = 4;
  localparam int BY = DW / 8;

  logic          clk;
  logic          reset;
  logic          aw_push;
  logic [LW-1:0] aw_len;
  logic          cmd_full;
  logic [DW-1:0] src_data;
  logic          src_valid;
  logic          src_ready;
  logic [DW-1:0] wdata;
  logic [BY-1:0] wstrb;
  logic          wlast;
  logic          wvalid;
  logic          wready;
  logic          burst_done;
  logic          busy;
  logic          err_clr;
  logic          err_ovf;

  int n_chk;
  int n_err;
  int unsigned wcnt;
  int push_q[$];
  int exp_len[$];
  logic [BY-1:0] strb_ones;

  axi_wbeat_gen #(
    .AXI_DW (DW),
    .AXI_LW (LW),
    .CMD_D  (CD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .aw_push    (aw_push),
    .aw_len     (aw_len),
    .cmd_full   (cmd_full),
    .src_data   (src_data),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .wlast      (wlast),
    .wvalid     (wvalid),
    .wready     (wready),
    .burst_done (burst_done),
    .busy       (busy),
    .err_clr    (err_clr),
    .err_ovf    (err_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] word(input int unsigned i);
    return DW'(32'hC0DE_0000 + i);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    aw_push   = 1'b0;
    aw_len    = '0;
    src_valid = 1'b0;
    wready    = 1'b0;
    err_clr   = 1'b0;
    src_data  = word(wcnt);
    repeat (2) step();
    reset = 1'b0;
  endtask

  // Pushes push_q one per cycle while consuming beats; checks every beat
  // against the expected burst lengths until all bursts complete.
  task automatic drain(input int max_cyc, input bit bp,
                       output int first_cyc, output int last_cyc, output int nbeats);
    int   target;
    int   bi;
    int   ndone;
    bit   stalled;
    bit   keep_v;
    bit   finished;
    logic [DW-1:0] hold_d;
    logic hold_l;
    target    = exp_len.size() + push_q.size();
    bi        = 0;
    ndone     = 0;
    stalled   = 1'b0;
    keep_v    = 1'b0;
    finished  = 1'b0;
    first_cyc = -1;
    last_cyc  = -1;
    nbeats    = 0;
    for (int c = 0; c < max_cyc && !finished; c++) begin
      step();
      if (push_q.size() > 0) begin
        aw_push = 1'b1;
        aw_len  = LW'(push_q[0]);
        exp_len.push_back(push_q.pop_front());
      end else begin
        aw_push = 1'b0;
      end
      if (bp) begin
        wready = 1'($urandom_range(0, 1));
        if (!keep_v) src_valid = 1'($urandom_range(0, 1));
      end else begin
        wready    = 1'b1;
        src_valid = 1'b1;
      end
      src_data = word(wcnt);
      #1;
      if (stalled) begin
        chk("stall_wvalid", 64'(wvalid), 64'(1));
        chk("stall_wdata", 64'(wdata), 64'(hold_d));
        chk("stall_wlast", 64'(wlast), 64'(hold_l));
      end
      if (wvalid && wready) begin
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
        nbeats++;
        chk("wdata", 64'(wdata), 64'(word(wcnt)));
        chk("wstrb", 64'(wstrb), 64'(strb_ones));
        chk("src_ready", 64'(src_ready), 64'(1));
        if (exp_len.size() == 0) begin
          chk("spurious_beat", 64'(1), 64'(0));
        end else begin
          chk("wlast", 64'(wlast), 64'(bi == exp_len[0]));
          chk("burst_done", 64'(burst_done), 64'(bi == exp_len[0]));
          if (bi == exp_len[0]) begin
            void'(exp_len.pop_front());
            bi = 0;
            ndone++;
          end else begin
            bi++;
          end
        end
        wcnt++;
      end else begin
        chk("done_idle", 64'(burst_done), 64'(0));
      end
      stalled = wvalid & ~wready;
      hold_d  = wdata;
      hold_l  = wlast;
      keep_v  = src_valid & ~src_ready;
      if (ndone == target) finished = 1'b1;
    end
    chk("bursts_done", 64'(ndone), 64'(target));
    step();
    aw_push   = 1'b0;
    wready    = 1'b0;
    src_valid = 1'b0;
    #1;
    chk("busy_after", 64'(busy), 64'(0));
    chk("wvalid_after", 64'(wvalid), 64'(0));
    exp_len.delete();
  endtask

  initial begin
    int f;
    int l;
    int nb;
    n_chk     = 0;
    n_err     = 0;
    wcnt      = 0;
    strb_ones = '1;

    // Reset state with source and sink both eager
    do_reset();
    src_valid = 1'b1;
    wready    = 1'b1;
    #1;
    chk("rst_wvalid", 64'(wvalid), 64'(0));
    chk("rst_src_ready", 64'(src_ready), 64'(0));
    chk("rst_wlast", 64'(wlast), 64'(0));
    chk("rst_wstrb", 64'(wstrb), 64'(0));
    chk("rst_cmd_full", 64'(cmd_full), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err_ovf", 64'(err_ovf), 64'(0));
    chk("rst_burst_done", 64'(burst_done), 64'(0));

    // Single burst of 4 beats
    push_q = '{3};
    drain(100, 1'b0, f, l, nb);
    chk("single_first", 64'(f), 64'(2));
    chk("single_last", 64'(l), 64'(5));
    chk("single_beats", 64'(nb), 64'(4));

    // Back-to-back 1+2+16 beats, contiguous
    push_q = '{0, 1, 15};
    drain(200, 1'b0, f, l, nb);
    chk("b2b_first", 64'(f), 64'(2));
    chk("b2b_last", 64'(l), 64'(20));
    chk("b2b_beats", 64'(nb), 64'(19));

    // Backpressure on both sides
    push_q = '{7};
    drain(500, 1'b1, f, l, nb);
    chk("bp_beats", 64'(nb), 64'(8));

    // Maximum length
    push_q = '{255};
    drain(600, 1'b0, f, l, nb);
    chk("max_first", 64'(f), 64'(2));
    chk("max_last", 64'(l), 64'(257));
    chk("max_beats", 64'(nb), 64'(256));

    // Fill the queue with W stalled: first command moves into DATA, four more fill it
    wready    = 1'b0;
    src_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      aw_push = 1'b1;
      aw_len  = '0;
      #1;
      if (i == 4) chk("full_before_5th", 64'(cmd_full), 64'(0));
    end
    step();
    aw_push = 1'b0;
    #1;
    chk("full_set", 64'(cmd_full), 64'(1));
    chk("ovf_clear_yet", 64'(err_ovf), 64'(0));
    chk("full_busy", 64'(busy), 64'(1));
    step();
    aw_push = 1'b1;
    aw_len  = LW'(5);
    #1;
    step();
    aw_push = 1'b0;
    #1;
    chk("ovf_set", 64'(err_ovf), 64'(1));
    chk("ovf_full_kept", 64'(cmd_full), 64'(1));
    step();
    aw_push = 1'b1;
    err_clr = 1'b1;
    #1;
    step();
    aw_push = 1'b0;
    err_clr = 1'b0;
    #1;
    chk("ovf_set_beats_clr", 64'(err_ovf), 64'(1));
    step();
    err_clr = 1'b1;
    #1;
    step();
    err_clr = 1'b0;
    #1;
    chk("ovf_cleared", 64'(err_ovf), 64'(0));
    exp_len = '{0, 0, 0, 0, 0};
    drain(100, 1'b0, f, l, nb);
    chk("ovf_drain_first", 64'(f), 64'(0));
    chk("ovf_drain_beats", 64'(nb), 64'(5));

    // Reset after beat 3 of an 8-beat burst with two commands queued
    wready    = 1'b0;
    src_valid = 1'b0;
    step(); aw_push = 1'b1; aw_len = LW'(7);
    step(); aw_len = LW'(2);
    step(); aw_len = LW'(3);
    step(); aw_push = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      wready    = 1'b1;
      src_valid = 1'b1;
      src_data  = word(wcnt);
      #1;
      chk("rm_wvalid", 64'(wvalid), 64'(1));
      chk("rm_wlast", 64'(wlast), 64'(0));
      wcnt++;
    end
    step();
    reset = 1'b1;
    #1;
    chk("rm_no_done", 64'(burst_done), 64'(0));
    step();
    #1;
    chk("rm_wvalid0", 64'(wvalid), 64'(0));
    chk("rm_src_ready0", 64'(src_ready), 64'(0));
    chk("rm_wlast0", 64'(wlast), 64'(0));
    chk("rm_wstrb0", 64'(wstrb), 64'(0));
    chk("rm_done0", 64'(burst_done), 64'(0));
    chk("rm_busy0", 64'(busy), 64'(0));
    chk("rm_full0", 64'(cmd_full), 64'(0));
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      #1;
      chk("rm_discard_wvalid", 64'(wvalid), 64'(0));
      chk("rm_discard_busy", 64'(busy), 64'(0));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
